uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with the UART transmitter: consumes the TX line of a remote
//  (or looped-back) transmitter, recovers 8N1 frames using the shared 16x brg_en tick,
//  and presents parallel bytes with a rdy/clr_rdy handshake to the host-side logic.
//  Sits downstream of the TX pin / loopback path and upstream of the register interface.
// PARAMETERS
//  DATA_BITS    8  payload bits per frame, LSB first (legal 5..8)
//  SYNC_STAGES  2  flops in the RX metastability synchronizer (legal 2..3)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          synchronous active-low reset (sampled on posedge clk)
//  RX           in   1          asynchronous serial input, idles high
//  brg_en       in   1          1-cycle pulse at 16x the baud rate (same tick as TX side)
//  clr_rdy      in   1          host acknowledge; clears rdy and overrun
//  rx_data      out  DATA_BITS  last correctly framed byte
//  rdy          out  1          rx_data holds an unacknowledged byte
//  framing_err  out  1          last frame had stop bit = 0 (sticky until next good frame)
//  overrun      out  1          good frame completed while rdy was still 1
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all synchronizer flops <= 1, state <= IDLE, counters <= 0,
//    rx_data <= 0, rdy <= 0, framing_err <= 0, overrun <= 0. Reset mid-frame aborts the frame.
//  - rx_s = RX after SYNC_STAGES flops; all decisions use rx_s only.
//  - baud_cnt (4b) increments on brg_en; cleared on every state entry and every sample point.
//  - bit_cnt counts data bits received; cleared on entry to DATA.
//  - FSM:
//    IDLE : rx_s==0 -> START (clear baud_cnt). No brg_en needed to detect the edge.
//    START: sample point = brg_en && baud_cnt==7 (mid start bit).
//           sample==0 -> DATA; sample==1 -> IDLE (glitch, no flags touched).
//    DATA : sample point = brg_en && baud_cnt==15. Shift sample into MSB of shift reg
//           (right shift, LSB first). After DATA_BITS samples -> STOP.
//    STOP : sample point = brg_en && baud_cnt==15.
//           sample==1: rx_data <= shift reg, rdy <= 1, framing_err <= 0,
//                      overrun <= rdy_old (1 if previous byte unacknowledged).
//           sample==0: framing_err <= 1; rx_data, rdy, overrun unchanged.
//           Either way -> IDLE in the same cycle (mid stop bit), so back-to-back
//           frames with a single stop bit are received.
//  - Outputs update on the clock edge of the STOP sample point (1 clk after the tick).
//  - clr_rdy: rdy <= 0, overrun <= 0. clr_rdy in the same cycle as a good STOP sample:
//    set wins (rdy=1) and overrun <= 0 (the old byte was acknowledged).
//  - rx_data is held stable while rdy=1 unless overwritten by a newer good frame.
//  - brg_en absent: FSM holds in current state indefinitely (no timeout).
//  - RX stuck low (break): START->DATA->STOP(frame err)->IDLE->START repeats; rdy never set.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample point value = 2-of-3 majority of rx_s captured
//    on the brg_en ticks at baud_cnt = N-2, N-1, N (N = 7 in START, 15 in DATA/STOP);
//    sample timing and latency unchanged. Rejects single-tick glitches.
//  UART_RX_MAJORITY_EN undefined: sample value = rx_s on the tick at baud_cnt==N only;
//    majority flops not instantiated.
// TESTING
//  1 Reset: drive RX=1, rst_n=0 2 clks -> rdy=0, framing_err=0, overrun=0, rx_data=8'h00.
//  2 Loopback with the transmitter, tx_data=8'hA5 -> rdy=1 within 1 clk after mid stop bit,
//    rx_data=8'hA5, framing_err=0; clr_rdy 1 clk -> rdy=0 next cycle.
//  3 Back-to-back 8'h00 then 8'hFF, no clr_rdy -> rx_data=8'hFF, rdy=1, overrun=1;
//    clr_rdy -> overrun=0, rdy=0.
//  4 Frame 8'h3C with stop bit forced 0 -> framing_err=1, rdy=0, rx_data unchanged;
//    next good frame 8'h11 -> framing_err=0, rx_data=8'h11.
//  5 RX low pulse of 4 brg_en ticks in IDLE -> FSM returns to IDLE, no flag change;
//    with UART_RX_MAJORITY_EN, 1-tick low glitch at data-bit midpoint of 8'hFF -> rx_data=8'hFF.
//  6 rst_n=0 asserted mid DATA of a frame -> state IDLE, rdy=0; next full frame 8'h5A
//    received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by the shared 16x baud tick (brg_en).
// RX is synchronized, the start bit is confirmed at mid-bit, data and stop bits
// are sampled at their centres, and completed bytes are offered with rdy/clr_rdy.
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote over
// the last three baud ticks so single-tick glitches on the line are rejected.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 brg_en,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 framing_err,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             baud_cnt_q, baud_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rdy_q, rdy_d;
    logic                   framing_err_q, framing_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;
    logic                   sample_val;

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // Remember rx_s from the two previous baud ticks for the 2-of-3 vote.
    always_comb begin
        hist_d = hist_q;
        if (brg_en) begin
            hist_d = {hist_q[0], rx_s};
        end
    end

    // Vote history register; idles high like the line itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign sample_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample_val = rx_s;
`endif

    // Next-state logic: synchronizer shift, frame FSM, output flags and handshake.
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], RX};
        baud_cnt_d    = baud_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rdy_d         = rdy_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                baud_cnt_d = 4'd0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (brg_en) begin
                    if (baud_cnt_q == 4'd7) begin
                        baud_cnt_d = 4'd0;
                        if (!sample_val) begin
                            state_d   = DATA;
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (brg_en) begin
                    if (baud_cnt_q == 4'd15) begin
                        baud_cnt_d = 4'd0;
                        shift_d    = {sample_val, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (brg_en) begin
                    if (baud_cnt_q == 4'd15) begin
                        baud_cnt_d = 4'd0;
                        state_d    = IDLE;
                        if (sample_val) begin
                            rx_data_d     = shift_q;
                            rdy_d         = 1'b1;
                            framing_err_d = 1'b0;
                            overrun_d     = rdy_q & ~clr_rdy;
                        end else begin
                            framing_err_d = 1'b1;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; a reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sync_q        <= '1;
            baud_cnt_q    <= 4'd0;
            bit_cnt_q     <= 4'd0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rdy_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rdy_q         <= rdy_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rdy         = rdy_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A behavioural transmitter drives RX in
// step with a bench-generated 16x tick; each frame's expectation is queued when it
// is sent and retired against a reference model at the stop-bit sample point.
module tb_uart_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RX      = 1'b1;
    logic       brg_en  = 1'b0;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       framing_err;
    logic       overrun;

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .brg_en     (brg_en),
        .clr_rdy    (clr_rdy),
        .rx_data    (rx_data),
        .rdy        (rdy),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Baud tick: one clock wide every fourth clock, changed on the falling edge.
    int brgDiv = 0;
    initial begin
        forever begin
            @(negedge clk);
            brgDiv = (brgDiv + 1) % 4;
            brg_en = (brgDiv == 0);
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       stopBit;
        logic       clrAtStop;
    } frame_t;

    frame_t     expQ[$];
    logic [7:0] modelData = 8'h00;
    logic       modelRdy  = 1'b0;
    logic       modelFerr = 1'b0;
    logic       modelOvr  = 1'b0;
    int         checkCount = 0;
    int         passCount  = 0;
    int         failCount  = 0;

    // Safety net so the run always ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".rx_data"}, rx_data, modelData);
        check({tag, ".rdy"}, {7'd0, rdy}, {7'd0, modelRdy});
        check({tag, ".framing_err"}, {7'd0, framing_err}, {7'd0, modelFerr});
        check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, modelOvr});
    endtask

    // Returns just after the next clock edge on which brg_en is high.
    task automatic waitTick();
        do @(posedge clk); while (brg_en !== 1'b1);
        #1;
    endtask

    task automatic waitTicks(input int n);
        repeat (n) waitTick();
    endtask

    // Sends one frame starting at the current tick; glitchBit >= 0 pulls that data
    // bit low for the single tick at its midpoint.
    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic stopBit,
                                 input logic clrAtStop, input int glitchBit);
        frame_t f;
        f.data      = data;
        f.stopBit   = stopBit;
        f.clrAtStop = clrAtStop;
        expQ.push_back(f);

        RX = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            if (i == glitchBit) begin
                waitTicks(7);
                RX = 1'b0;
                waitTick();
                RX = data[i];
                waitTicks(8);
            end else begin
                waitTicks(16);
            end
        end
        RX = stopBit;
        waitTicks(7);
        check({tag, ".preStop.rdy"}, {7'd0, rdy}, {7'd0, modelRdy});
        if (clrAtStop) begin
            repeat (3) @(posedge clk);
            #1 clr_rdy = 1'b1;
        end
        waitTick();
        clr_rdy = 1'b0;

        f = expQ.pop_front();
        if (f.stopBit) begin
            modelOvr  = modelRdy & ~f.clrAtStop;
            modelRdy  = 1'b1;
            modelData = f.data;
            modelFerr = 1'b0;
        end else begin
            modelFerr = 1'b1;
            if (f.clrAtStop) begin
                modelRdy = 1'b0;
                modelOvr = 1'b0;
            end
        end
        checkOutput(tag);

        RX = 1'b1;
        waitTicks(stopBit ? 8 : 24);
    endtask

    // One-cycle host acknowledge, then realign to the baud tick.
    task automatic clrPulse(input string tag);
        @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
        modelRdy = 1'b0;
        modelOvr = 1'b0;
        checkOutput(tag);
        waitTick();
    endtask

    initial begin
        // Reset with the line idle.
        rst_n = 1'b0;
        RX    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;
        waitTicks(4);

        // Single good frame, then acknowledge.
        applyStimulus("frameA5", 8'hA5, 1'b1, 1'b0, -1);
        clrPulse("clrA5");

        // Back-to-back frames without acknowledge produce overrun.
        applyStimulus("frame00", 8'h00, 1'b1, 1'b0, -1);
        applyStimulus("frameFF", 8'hFF, 1'b1, 1'b0, -1);
        clrPulse("clrOverrun");

        // Acknowledge landing on the stop sample: rdy set wins, overrun cleared.
        applyStimulus("frame77", 8'h77, 1'b1, 1'b0, -1);
        applyStimulus("frame88clr", 8'h88, 1'b1, 1'b1, -1);
        clrPulse("clr88");

        // Bad stop bit, then recovery with a good frame.
        applyStimulus("frame3Cbad", 8'h3C, 1'b0, 1'b0, -1);
        applyStimulus("frame11", 8'h11, 1'b1, 1'b0, -1);

        // Short low pulse in idle is rejected as a false start.
        RX = 1'b0;
        waitTicks(4);
        RX = 1'b1;
        waitTicks(24);
        checkOutput("falseStart");

`ifdef UART_RX_MAJORITY_EN
        applyStimulus("majorityFF", 8'hFF, 1'b1, 1'b0, 3);
`endif

        // Reset in the middle of the data bits aborts the frame.
        RX = 1'b0;
        waitTicks(16);
        RX = 1'b1;
        waitTicks(40);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelData = 8'h00;
        modelRdy  = 1'b0;
        modelFerr = 1'b0;
        modelOvr  = 1'b0;
        checkOutput("midReset");
        waitTicks(20);
        applyStimulus("frame5A", 8'h5A, 1'b1, 1'b0, -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
